// File: rtl/pumpn_ctrl.sv
// Peristaltic N-valve pump sequencer: walks the air lines through a 2N-step closed-valve pattern
// with programmable step period and stroke count. Define PUMP_DIR_EN to add a reverse-pumping dir input.
module pumpn_ctrl #(
    parameter int unsigned N_VALVES = 3,
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned STROKE_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
`ifdef PUMP_DIR_EN
    input  logic                          dir,
`endif
    input  logic [PERIOD_W-1:0]           period,
    input  logic [STROKE_W-1:0]           strokes,
    output logic [N_VALVES-1:0]           air,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(2*N_VALVES)-1:0] step_idx,
    output logic [STROKE_W-1:0]           stroke_cnt
);
    localparam int unsigned Steps = 2 * N_VALVES;
    localparam int unsigned StepW = $clog2(Steps);
    localparam logic [StepW-1:0] LastStep = StepW'(Steps - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e                state_q, state_d;
    logic [PERIOD_W-1:0]   period_q, period_d;
    logic [PERIOD_W-1:0]   timer_q, timer_d;
    logic [STROKE_W-1:0]   strokes_q, strokes_d;
    logic [STROKE_W-1:0]   cnt_q, cnt_d;
    logic [StepW-1:0]      step_q, step_d;
    logic [N_VALVES-1:0]   air_q, air_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  stop_q, stop_d;
    logic                  dir_q, dir_d;
    logic                  dir_in;

    logic                  step_end;
    logic                  wrap;
    logic [STROKE_W-1:0]   cnt_inc;
    logic [StepW-1:0]      step_next;

`ifdef PUMP_DIR_EN
    assign dir_in = dir;
`else
    assign dir_in = 1'b0;
`endif

    // Step s closes valve s/2, plus its successor on odd steps; rev mirrors the valve order.
    function automatic logic [N_VALVES-1:0] pattern(input logic [StepW-1:0] s, input logic rev);
        logic [N_VALVES-1:0] fwd;
        logic [N_VALVES-1:0] res;
        int i;
        i = int'(s >> 1);
        for (int j = 0; j < int'(N_VALVES); j++) begin
            fwd[j] = (j == i) || (s[0] && (j == (i + 1) % int'(N_VALVES)));
        end
        for (int j = 0; j < int'(N_VALVES); j++) begin
            res[j] = rev ? fwd[int'(N_VALVES) - 1 - j] : fwd[j];
        end
        return res;
    endfunction

    assign step_end  = (timer_q == period_q - 1'b1);
    assign wrap      = (step_q == LastStep);
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign step_next = wrap ? '0 : step_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        strokes_d = strokes_q;
        dir_d     = dir_q;
        timer_d   = timer_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        stop_d    = stop_q;
        air_d     = air_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRun;
                    period_d  = (period == '0) ? PERIOD_W'(1) : period;
                    strokes_d = strokes;
                    dir_d     = dir_in;
                    timer_d   = '0;
                    step_d    = '0;
                    cnt_d     = '0;
                    stop_d    = 1'b0;
                    busy_d    = 1'b1;
                    air_d     = pattern('0, dir_in);
                end
            end
            StRun: begin
                if (stop) stop_d = 1'b1;
                if (step_end) begin
                    timer_d = '0;
                    if (wrap) cnt_d = cnt_inc;
                    // A stop raised on the boundary cycle itself still ends this step.
                    if ((wrap && strokes_q != '0 && cnt_inc == strokes_q) || stop_q || stop) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        air_d   = '1;
                        step_d  = '0;
                        stop_d  = 1'b0;
                    end else begin
                        step_d = step_next;
                        air_d  = pattern(step_next, dir_q);
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            period_q  <= PERIOD_W'(1);
            strokes_q <= '0;
            dir_q     <= 1'b0;
            timer_q   <= '0;
            step_q    <= '0;
            cnt_q     <= '0;
            stop_q    <= 1'b0;
            air_q     <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            strokes_q <= strokes_d;
            dir_q     <= dir_d;
            timer_q   <= timer_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            stop_q    <= stop_d;
            air_q     <= air_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign air        = air_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign step_idx   = step_q;
    assign stroke_cnt = cnt_q;

endmodule

// File: tb/tb_pumpn_ctrl.sv
// Randomised and directed bench for pumpn_ctrl: a 3-valve and a 4-valve instance checked every
// cycle against a timeline model (busy cycle k sits in step (k/P) mod 2N, stroke k/(2N*P)).
module tb_pumpn_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        dir_v = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] period = '0;
    logic [15:0] strokes = '0;

    logic [2:0]  air3;
    logic [3:0]  air4;
    logic        busy3, busy4, done3, done4;
    logic [2:0]  step3, step4;
    logic [15:0] cnt3, cnt4;

    logic [15:0] obs_air;
    logic        obs_busy, obs_done;
    logic [7:0]  obs_step;
    logic [15:0] obs_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pumpn_ctrl #(.N_VALVES(3), .PERIOD_W(16), .STROKE_W(16)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .start      (start & ~sel),
        .stop       (stop & ~sel),
`ifdef PUMP_DIR_EN
        .dir        (dir_v),
`endif
        .period     (period),
        .strokes    (strokes),
        .air        (air3),
        .busy       (busy3),
        .done       (done3),
        .step_idx   (step3),
        .stroke_cnt (cnt3)
    );

    pumpn_ctrl #(.N_VALVES(4), .PERIOD_W(16), .STROKE_W(16)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start & sel),
        .stop       (stop & sel),
`ifdef PUMP_DIR_EN
        .dir        (dir_v),
`endif
        .period     (period),
        .strokes    (strokes),
        .air        (air4),
        .busy       (busy4),
        .done       (done4),
        .step_idx   (step4),
        .stroke_cnt (cnt4)
    );

    always_comb begin
        obs_air  = sel ? 16'(air4) : 16'(air3);
        obs_busy = sel ? busy4 : busy3;
        obs_done = sel ? done4 : done3;
        obs_step = sel ? 8'(step4) : 8'(step3);
        obs_cnt  = sel ? cnt4 : cnt3;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Closed valves for step s: s/2 and, on odd steps, its successor; reverse mirrors indices.
    function automatic logic [31:0] model_air(input int n, input int s, input bit rev);
        int a, b;
        logic [31:0] r;
        a = s / 2;
        b = (s % 2 == 1) ? (a + 1) % n : a;
        if (rev) begin
            a = n - 1 - a;
            b = n - 1 - b;
        end
        r = (32'd1 << a) | (32'd1 << b);
        return r;
    endfunction

    // ks: busy cycle on which stop is high (-1 none); kstart: busy cycle with a stray start.
    task automatic run_pump(input bit s, input int p, input int nstr, input int ks,
                            input int kstart, input bit both, input bit rev);
        int n, pe, slen, l, st;
        n    = s ? 4 : 3;
        pe   = (p == 0) ? 1 : p;
        slen = 2 * n * pe;
        l    = (nstr == 0) ? (1 << 30) : slen * nstr;
        if (ks >= 0 && ks < l) l = (ks / pe + 1) * pe;
        sel     = s;
        period  = 16'(p);
        strokes = 16'(nstr);
        dir_v   = rev;
        start   = 1'b1;
        stop    = both;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        for (int k = 0; k < l; k++) begin
            st = (k / pe) % (2 * n);
            check_eq("busy", 32'(obs_busy), 32'd1);
            check_eq("done_run", 32'(obs_done), 32'd0);
            check_eq("air", 32'(obs_air), model_air(n, st, rev));
            check_eq("step_idx", 32'(obs_step), 32'(st));
            check_eq("stroke_cnt_run", 32'(obs_cnt), 32'(k / slen));
            stop    = (k == ks);
            start   = (k == kstart);
            period  = 16'($urandom);
            strokes = 16'($urandom);
            dir_v   = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        stop  = 1'b0;
        check_eq("busy_end", 32'(obs_busy), 32'd0);
        check_eq("done_pulse", 32'(obs_done), 32'd1);
        check_eq("air_end", 32'(obs_air), (32'd1 << n) - 32'd1);
        check_eq("step_end", 32'(obs_step), 32'd0);
        check_eq("stroke_cnt_end", 32'(obs_cnt), 32'(l / slen));
        @(negedge clk);
        check_eq("done_single", 32'(obs_done), 32'd0);
        check_eq("busy_idle", 32'(obs_busy), 32'd0);
        check_eq("cnt_hold", 32'(obs_cnt), 32'(l / slen));
    endtask

    initial begin
        int p, ns, ks, kst, n;
        bit s, rv;
        repeat (2) @(negedge clk);
        check_eq("rst_air3", 32'(air3), 32'h7);
        check_eq("rst_air4", 32'(air4), 32'hf);
        check_eq("rst_busy", 32'(busy3 | busy4), 32'd0);
        check_eq("rst_done", 32'(done3 | done4), 32'd0);
        check_eq("rst_step", 32'(step3 | step4), 32'd0);
        check_eq("rst_cnt", 32'(cnt3 | cnt4), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_pump(1'b0, 2, 1, -1, -1, 1'b0, 1'b0);
        run_pump(1'b0, 0, 2, -1, -1, 1'b0, 1'b0);
        run_pump(1'b1, 3, 0, 16, -1, 1'b0, 1'b0);
        run_pump(1'b0, 1, 1, 5, -1, 1'b0, 1'b0);
        run_pump(1'b0, 1, 2, 5, -1, 1'b0, 1'b0);
        run_pump(1'b0, 1, 1, -1, 3, 1'b0, 1'b0);
        run_pump(1'b0, 2, 1, -1, -1, 1'b1, 1'b0);

        // Asynchronous reset mid-step, then a clean restart.
        sel     = 1'b0;
        period  = 16'd3;
        strokes = 16'd0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_air", 32'(air3), 32'h7);
        check_eq("mid_rst_busy", 32'(busy3), 32'd0);
        check_eq("mid_rst_done", 32'(done3), 32'd0);
        check_eq("mid_rst_step", 32'(step3), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_done", 32'(done3), 32'd0);
        check_eq("post_rst_busy", 32'(busy3), 32'd0);
        run_pump(1'b0, 2, 1, -1, -1, 1'b0, 1'b0);

`ifdef PUMP_DIR_EN
        run_pump(1'b0, 1, 1, -1, -1, 1'b0, 1'b1);
        run_pump(1'b1, 2, 1, -1, -1, 1'b0, 1'b1);
`endif

        for (int r = 0; r < 10; r++) begin
            s   = 1'($urandom);
            n   = s ? 4 : 3;
            p   = int'($urandom_range(0, 4));
            ns  = int'($urandom_range(0, 3));
            ks  = ($urandom_range(0, 1) == 1 || ns == 0) ?
                  int'($urandom_range(0, 2 * n * 4 * 3 - 1)) : -1;
            kst = int'($urandom_range(0, 20));
`ifdef PUMP_DIR_EN
            rv  = 1'($urandom);
`else
            rv  = 1'b0;
`endif
            run_pump(s, p, ns, ks, kst, 1'($urandom), rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
